bf16_acc_seq: RTL

BF16_ACC_SEQ -- requirements
Module: bf16_acc_seq

---
 rtl/bf16_acc_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/bf16_acc_seq.sv
// rtl/bf16_acc_seq.sv - bf16 packet accumulator sequencer around an external combinational adder
module bf16_acc_seq #(
    parameter int E = 8,
    parameter int M = 7
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E+M:0] in_data,
    input  logic         in_last,
    output logic         sa_o,
    output logic [E-1:0] ea_o,
    output logic [M-1:0] ma_o,
    output logic         sb_o,
    output logic [E-1:0] eb_o,
    output logic [M-1:0] mb_o,
    input  logic         s_i,
    input  logic [E-1:0] e_i,
    input  logic [M-1:0] m_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E+M:0] out_data,
    output logic [15:0]  out_count
);

    localparam int W = 1 + E + M;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   acc;
    logic [15:0]    cnt;
    logic           in_hs;
    logic           out_hs;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // Adder operands are always presented; the sum is only consumed in ACC.
    assign {sa_o, ea_o, ma_o} = acc;
    assign {sb_o, eb_o, mb_o} = in_data;

    assign out_data  = acc;
    assign out_count = cnt;

    // State register; reset discards any partial or pending packet at once.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = (state != DONE);
        out_valid = (state == DONE);
        case (state)
            IDLE: if (in_hs) state_nxt = in_last ? DONE : ACC;
            ACC:  if (in_hs) state_nxt = in_last ? DONE : ACC;
            DONE: if (out_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator and element counter; the first element loads without an add.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_hs) begin
            if (state == IDLE) begin
                acc <= in_data;
                cnt <= 16'd1;
            end else begin
                acc <= {s_i, e_i, m_i};
                if (cnt != 16'hFFFF) begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

endmodule
